// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed/unsigned per transaction, truncated result with overflow flag.
// Latency: operands accepted at edge E give out_valid from edge E+WIDTH; one transaction per WIDTH+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY/DONE, no comb ready/valid paths.
module seq_multiplier #(
  parameter int WIDTH     = 4,
  parameter int OUT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] p,
  output logic                 ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  // Mask covering bits [PW-1:OUT_WIDTH-1] after shifting them down to bit 0.
  localparam logic [PW-1:0] SMASK = {PW{1'b1}} >> (OUT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   a_sh;      // |a| shifted left by count
  logic [WIDTH-1:0] b_sh;     // |b| shifted right by count; bit 0 is the current multiplier bit
  logic [CW-1:0]   count;
  logic            neg;
  logic            sgn;

  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    full;
  logic [PW-1:0]    hi;
  logic             last_bit;
  logic             ovf_u;
  logic             ovf_s;
  logic             ovf_nxt;

  // Operand magnitudes at accept; -2^(WIDTH-1) negates to itself, which read unsigned is 2^(WIDTH-1).
  always_comb begin
    a_mag_in = (in_signed && a[WIDTH-1]) ? -a : a;
    b_mag_in = (in_signed && b[WIDTH-1]) ? -b : b;
  end

  // Partial-product step and signed result formation; full includes the final step's addend.
  always_comb begin
    acc_sum  = acc + (b_sh[0] ? a_sh : '0);
    full     = neg ? -acc_sum : acc_sum;
    last_bit = (count == CW'(WIDTH - 1));
    hi       = full >> (OUT_WIDTH - 1);
    ovf_s    = (hi != '0) && (hi != SMASK);
    ovf_nxt  = sgn ? ovf_s : ovf_u;
  end

  // Unsigned overflow: any bit above the kept slice is set; impossible when nothing is truncated.
  generate
    if (OUT_WIDTH == PW) begin : g_no_trunc
      assign ovf_u = 1'b0;
    end else begin : g_trunc
      assign ovf_u = |(full >> OUT_WIDTH);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: latch operands on accept, one shift-add per BUSY cycle, capture result on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      count <= '0;
      neg   <= 1'b0;
      sgn   <= 1'b0;
      p     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= {{WIDTH{1'b0}}, a_mag_in};
            b_sh  <= b_mag_in;
            neg   <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn   <= in_signed;
            acc   <= '0;
            count <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_sum;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh >> 1;
          count <= count + CW'(1);
          if (last_bit) begin
            p   <= full[OUT_WIDTH-1:0];
            ovf <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic       clk;
  logic       rst;
  logic [1:0] in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_signed;
  logic       out_ready;

  logic       in_ready0, out_valid0, ovf0;
  logic [3:0] p0;
  logic       in_ready1, out_valid1, ovf1;
  logic [7:0] p1;

  int n_checks;
  int n_fail;

  logic [4:0] q0[$];   // {ovf, p} for the 4-bit result instance
  logic [8:0] q1[$];   // {ovf, p} for the 8-bit result instance

  seq_multiplier #(.WIDTH(4), .OUT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready0),
    .a(a), .b(b), .in_signed(in_signed),
    .out_valid(out_valid0), .out_ready(out_ready), .p(p0), .ovf(ovf0)
  );

  seq_multiplier #(.WIDTH(4), .OUT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready1),
    .a(a), .b(b), .in_signed(in_signed),
    .out_valid(out_valid1), .out_ready(out_ready), .p(p1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int inst);
    return (inst == 0) ? in_ready0 : in_ready1;
  endfunction

  function automatic logic vld(input int inst);
    return (inst == 0) ? out_valid0 : out_valid1;
  endfunction

  // Scoreboard monitors: pop and compare whenever a result handshake is about to happen.
  task automatic mon0();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) check("spurious_out0", {31'd0, out_valid0}, 32'd0);
        else begin
          e = q0.pop_front();
          check("p0", {28'd0, p0}, {28'd0, e[3:0]});
          check("ovf0", {31'd0, ovf0}, {31'd0, e[4]});
        end
      end
    end
  endtask

  task automatic mon1();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) check("spurious_out1", {31'd0, out_valid1}, 32'd0);
        else begin
          e = q1.pop_front();
          check("p1", {24'd0, p1}, {24'd0, e[7:0]});
          check("ovf1", {31'd0, ovf1}, {31'd0, e[8]});
        end
      end
    end
  endtask

  // Issue one transaction (called at posedge+1), push its expectation, and check latency to out_valid.
  task automatic send(input int inst, input logic [3:0] av, input logic [3:0] bv, input logic sg,
                      input logic [7:0] ep, input logic eo);
    int k;
    int lat;
    k = 0;
    while (!rdy(inst) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_before_send", {31'd0, rdy(inst)}, 32'd1);
    a = av; b = bv; in_signed = sg;
    in_valid[inst] = 1'b1;
    if (inst == 0) q0.push_back({eo, ep[3:0]});
    else           q1.push_back({eo, ep});
    @(posedge clk); #1;
    in_valid = 2'b00;
    lat = 0;
    while (!vld(inst) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, 4);
  endtask

  initial begin
    int seen;
    clk = 0; rst = 1; in_valid = 2'b00; a = 0; b = 0; in_signed = 0; out_ready = 1;
    n_checks = 0; n_fail = 0;
    fork
      mon0();
      mon1();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready0", {31'd0, in_ready0}, 32'd1);
    check("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
    check("rst_p0", {28'd0, p0}, 32'd0);
    check("rst_ovf0", {31'd0, ovf0}, 32'd0);
    check("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
    check("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // 4x4 truncating, unsigned and signed
    send(0, 4'd3,  4'd5,  1'b0, 8'h0F, 1'b0);
    send(0, 4'd7,  4'd3,  1'b0, 8'h05, 1'b1);
    send(0, 4'd15, 4'd15, 1'b0, 8'h01, 1'b1);
    send(0, 4'h8,  4'h8,  1'b1, 8'h00, 1'b1);
    send(0, 4'hE,  4'h3,  1'b1, 8'h0A, 1'b0);

    // 4x4 with full 8-bit result
    send(1, 4'hD,  4'h5,  1'b1, 8'hF1, 1'b0);
    send(1, 4'h8,  4'h8,  1'b1, 8'h40, 1'b0);
    send(1, 4'hF,  4'hF,  1'b0, 8'hE1, 1'b0);
    send(1, 4'h7,  4'h8,  1'b1, 8'hC8, 1'b0);

    // Backpressure: result must hold and new requests must be ignored
    out_ready = 0;
    send(0, 4'd9, 4'd9, 1'b0, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("bp_p0", {28'd0, p0}, 32'h1);
      check("bp_ovf0", {31'd0, ovf0}, 32'd1);
      check("bp_in_ready0", {31'd0, in_ready0}, 32'd0);
      a = 4'd3; b = 4'd3; in_signed = 0;
      in_valid[0] = (i % 2 == 0);
      @(posedge clk); #1;
    end
    in_valid = 2'b00;
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_release_in_ready0", {31'd0, in_ready0}, 32'd1);
    check("bp_release_out_valid0", {31'd0, out_valid0}, 32'd0);

    // Reset in the middle of BUSY (count=2) discards the transaction
    a = 4'd5; b = 4'd7; in_signed = 0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("midrst_in_ready0", {31'd0, in_ready0}, 32'd1);
    check("midrst_out_valid0", {31'd0, out_valid0}, 32'd0);
    check("midrst_p0", {28'd0, p0}, 32'd0);
    check("midrst_ovf0", {31'd0, ovf0}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid0) seen++;
    end
    check("midrst_no_result", seen, 0);
    send(0, 4'd2, 4'd6, 1'b0, 8'h0C, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier, the successor to the team's fixed 4x4 combinational truncating multiplier. Operand width and result width are generic. Signed or unsigned mode is chosen per transaction, and an overflow flag reports truncation. Valid/ready handshakes on input and output let it sit between pipelined datapath stages and stall under backpressure.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.
OUT_WIDTH, 4, result width; result is the low OUT_WIDTH bits of the full 2*WIDTH product; legal range 1..2*WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands and mode present.
in_ready  output  1  block can accept a transaction.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
in_signed  input  1  1 = two's-complement operands and result; 0 = unsigned.
out_valid  output  1  result and ovf are valid.
out_ready  input  1  consumer accepts the result.
p  output  OUT_WIDTH  truncated product.
ovf  output  1  full product not representable in OUT_WIDTH bits.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset (rst=1 at an edge): state IDLE, in_ready=1, out_valid=0, p=0, ovf=0, internal accumulator and counter cleared. Reset overrides every other input.
- Reset mid-operation: the in-flight transaction is discarded and no result is produced.
- FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a, b and in_signed, clear the accumulator, set count=0, go to BUSY.
- Operand preparation (at accept, when in_signed=1):
  - Latch |a| and |b| as WIDTH-bit unsigned magnitudes. -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Latch neg = a[msb] XOR b[msb].
  - When in_signed=0: magnitudes are a and b, neg=0.
- BUSY:
  - in_ready=0, out_valid=0.
  - One multiplier bit per cycle, LSB first: if the current bit of |b| is 1, add |a| shifted by count into a 2*WIDTH-bit accumulator.
  - count increments each cycle; after WIDTH cycles go to DONE.
  - Inputs are ignored while BUSY.
- Result formation (on entry to DONE):
  - full = neg ? -acc : acc, in 2*WIDTH-bit two's complement.
  - p = full[OUT_WIDTH-1:0].
  - Unsigned ovf = 1 if any bit of full above OUT_WIDTH-1 is 1.
  - Signed ovf = 1 if full is not the sign-extension of p, i.e. bits [2*WIDTH-1:OUT_WIDTH-1] are not all equal.
  - When OUT_WIDTH=2*WIDTH, ovf is always 0.
- DONE:
  - out_valid=1, in_ready=0; p and ovf held stable until consumed.
  - On an edge with out_ready=1: go to IDLE, out_valid=0 next cycle.
  - No combinational ready/valid paths; back-to-back throughput is one transaction per WIDTH+2 cycles.
- Latency: operands accepted at edge E gives out_valid=1 from edge E+WIDTH through the handshake edge.
- Zero operands follow the normal path; no early termination, so latency is constant.
- p and ovf retain their last value in IDLE; consumers qualify them with out_valid.

Test Plan:
- WIDTH=4, OUT_WIDTH=4, unsigned a=3, b=5 -> p=15, ovf=0, out_valid exactly 4 cycles after accept.
- WIDTH=4, OUT_WIDTH=4, unsigned a=7, b=3 -> p=5, ovf=1. Then a=15, b=15 (225) -> p=1, ovf=1.
- WIDTH=4, OUT_WIDTH=8, signed: a=-3 (0xD), b=5 -> p=0xF1, ovf=0. Then a=-8, b=-8 -> p=0x40, ovf=0.
- WIDTH=4, OUT_WIDTH=4, signed a=-8, b=-8 -> p=0x0, ovf=1. Then a=-2, b=3 -> p=0xA, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> p/ovf stable, in_ready=0 throughout, in_valid pulses ignored. out_ready=1 -> in_ready=1 on the next cycle.
- Reset: assert rst for one cycle at count=2 of a BUSY transaction -> next cycle in_ready=1, out_valid=0, p=0, ovf=0, no result emitted. A following transaction a=2, b=6 -> p=12 (OUT_WIDTH=4), ovf=0.
